seri_verici_param: RTL and testbench

Parametrised serial transmitter FSM; the successor to the fixed 5-bit start/data/stop shifter. It sends one frame: start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits. Bit boundaries advance only on the baud-tick strobe `en`. New in this generation: the data word is captured at request time, a start request can be pended until the next tick, and a completion pulse is produced. It sits between a baud-tick generator and the serial output pin.

---
 rtl/seri_verici_param_if.sv | 12 +
 rtl/seri_verici_param.sv | 94 +++++++++
 tb/tb_seri_verici_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seri_verici_param_if.sv
// seri_verici_param_if: request/data/tick inputs and serial outputs of the parametrised serial transmitter
// master: en, D, baslat out; Y, mesgul, bitti in. slave: the transmitter side.
interface seri_verici_param_if #(parameter int DATA_W = 8);
  logic en;
  logic baslat;
  logic [DATA_W-1:0] D;
  logic Y;
  logic mesgul;
  logic bitti;
  modport master (output en, baslat, D, input Y, mesgul, bitti);
  modport slave (input en, baslat, D, output Y, mesgul, bitti);
endinterface

// File: rtl/seri_verici_param.sv
// seri_verici_param: serial frame transmitter (start, DATA_W bits LSB first, optional parity, 1-2 stop bits)
// Ports: clk, reset (async, active high), bus.en baud tick, bus.D data word, bus.baslat start request,
// bus.Y serial line (idle 1), bus.mesgul busy, bus.bitti one-cycle frame-complete pulse.
module seri_verici_param #(
  parameter int DATA_W = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic reset,
  seri_verici_param_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [1:0] SLAST = 2'(STOP_BITS - 1);
  localparam int I1 = DATA_W > 1 ? 1 : 0;
  typedef enum logic [2:0] {BOS, BEKLE, BASLA, VERI, PARITE, DUR} st_t;
  st_t st;
  logic [DATA_W-1:0] sr;
  logic par;
  logic [CW-1:0] cnt;
  logic [1:0] scnt;
  logic y, m, b;
  assign bus.Y = y;
  assign bus.mesgul = m;
  assign bus.bitti = b;
  // Outputs are loaded together with each state change so they always equal the state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= BOS;
      sr <= '0;
      par <= 1'b0;
      cnt <= '0;
      scnt <= '0;
      y <= 1'b1;
      m <= 1'b0;
      b <= 1'b0;
    end else begin
      b <= 1'b0;
      case (st)
        BOS: if (bus.baslat) begin
          sr <= bus.D;
          par <= (PARITY == 2) ^ (^bus.D);
          m <= 1'b1;
          if (bus.en) begin
            st <= BASLA;
            y <= 1'b0;
          end else st <= BEKLE;
        end
        BEKLE: if (bus.en) begin
          st <= BASLA;
          y <= 1'b0;
        end
        BASLA: if (bus.en) begin
          st <= VERI;
          cnt <= '0;
          y <= sr[0];
        end
        VERI: if (bus.en) begin
          if (cnt < LAST) begin
            sr <= sr >> 1;
            cnt <= cnt + CW'(1);
            y <= sr[I1];
          end else if (PARITY != 0) begin
            st <= PARITE;
            y <= par;
          end else begin
            st <= DUR;
            scnt <= '0;
            y <= 1'b1;
          end
        end
        PARITE: if (bus.en) begin
          st <= DUR;
          scnt <= '0;
          y <= 1'b1;
        end
        DUR: if (bus.en) begin
          if (scnt < SLAST) scnt <= scnt + 2'd1;
          else begin
            st <= BOS;
            m <= 1'b0;
            b <= 1'b1;
          end
        end
        default: begin
          st <= BOS;
          y <= 1'b1;
          m <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seri_verici_param.sv
// tb_seri_verici_param: directed checks of three transmitter configurations
module tb_seri_verici_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] fa, fb;
  always #5 clk = ~clk;
  seri_verici_param_if #(.DATA_W(8)) a_if ();
  seri_verici_param_if #(.DATA_W(8)) b_if ();
  seri_verici_param_if #(.DATA_W(5)) c_if ();
  seri_verici_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1)) ua (.clk(clk), .reset(reset), .bus(a_if.slave));
  seri_verici_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1)) ub (.clk(clk), .reset(reset), .bus(b_if.slave));
  seri_verici_param #(.DATA_W(5), .PARITY(0), .STOP_BITS(2)) uc (.clk(clk), .reset(reset), .bus(c_if.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_in(input int s, input logic e, input logic b, input logic [7:0] d);
    if (s == 0) begin
      a_if.en = e; a_if.baslat = b; a_if.D = d;
    end else if (s == 1) begin
      b_if.en = e; b_if.baslat = b; b_if.D = d;
    end else begin
      c_if.en = e; c_if.baslat = b; c_if.D = d[4:0];
    end
  endtask
  function automatic logic gy(input int s);
    return s == 0 ? a_if.Y : s == 1 ? b_if.Y : c_if.Y;
  endfunction
  function automatic logic gm(input int s);
    return s == 0 ? a_if.mesgul : s == 1 ? b_if.mesgul : c_if.mesgul;
  endfunction
  function automatic logic gb(input int s);
    return s == 0 ? a_if.bitti : s == 1 ? b_if.bitti : c_if.bitti;
  endfunction
  // One frame: request (pended or coincident with a tick), then n bit periods of gap clocks each,
  // then the return to idle with its bitti pulse. frz >= 0 stalls the ticks for 50 clocks before tick frz.
  task automatic run_frame(input int s, input logic [7:0] d, input logic [15:0] ex, input int n,
                           input bit co, input int gap, input int frz);
    @(negedge clk);
    set_in(s, co, 1'b1, d);
    @(negedge clk);
    set_in(s, 1'b0, 1'b0, ~d);
    chk("acc_busy", gm(s), 1);
    if (co) chk("basla_direct", gy(s), 0);
    else begin
      chk("bekle_y", gy(s), 1);
      repeat (2) @(negedge clk);
      chk("bekle_hold_y", gy(s), 1);
      chk("bekle_hold_m", gm(s), 1);
    end
    for (int k = co ? 1 : 0; k <= n; k++) begin
      if (k == frz)
        for (int j = 0; j < 5; j++) begin
          repeat (10) @(negedge clk);
          chk("frz_y", gy(s), 32'(ex[k-1]));
          chk("frz_m", gm(s), 1);
        end
      repeat (gap - 1) @(negedge clk);
      set_in(s, 1'b1, 1'b0, d ^ 8'h5A);
      @(negedge clk);
      set_in(s, 1'b0, 1'b0, d);
      if (k < n) begin
        chk($sformatf("bit%0d_y", k), gy(s), 32'(ex[k]));
        chk("bit_m", gm(s), 1);
      end else begin
        chk("end_bitti", gb(s), 1);
        chk("end_m", gm(s), 0);
        chk("end_y", gy(s), 1);
      end
    end
    @(negedge clk);
    chk("bitti_one", gb(s), 0);
    chk("idle_y", gy(s), 1);
  endtask
  initial begin
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_y", a_if.Y, 1);
    chk("rst_m", a_if.mesgul, 0);
    chk("rst_b", a_if.bitti, 0);
    chk("rst_cy", c_if.Y, 1);
    reset = 1'b0;
    // reset in the middle of the data bits
    @(negedge clk);
    set_in(0, 1'b1, 1'b1, 8'h00);
    repeat (3) begin
      @(negedge clk); set_in(0, 1'b0, 1'b0, 8'h00);
      @(negedge clk); set_in(0, 1'b1, 1'b0, 8'h00);
    end
    @(negedge clk);
    chk("pre_rst_y", a_if.Y, 0);
    chk("pre_rst_m", a_if.mesgul, 1);
    set_in(0, 1'b1, 1'b0, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_y", a_if.Y, 1);
    chk("async_rst_m", a_if.mesgul, 0);
    chk("async_rst_b", a_if.bitti, 0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 3) reset = 1'b0;
      if (i == 12) chk("post_rst_mid_m", a_if.mesgul, 0);
      set_in(0, i[0], 1'b0, 8'h00);
    end
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 8'h00);
    chk("post_rst_y", a_if.Y, 1);
    chk("post_rst_m", a_if.mesgul, 0);
    // even parity, pended request
    run_frame(0, 8'hA5, 16'b10101001010, 11, 1'b0, 4, -1);
    // odd parity, request coincident with a tick
    run_frame(1, 8'h01, 16'b10000000010, 11, 1'b1, 4, -1);
    // 5 data bits, no parity, two stop bits
    run_frame(2, 8'h13, 16'b11100110, 8, 1'b0, 3, -1);
    // long tick stall inside the data bits
    run_frame(0, 8'h3C, 16'b10001111000, 11, 1'b0, 2, 5);
    // baslat held high, D toggling every clock: only the acceptance cycles sample D
    fa = 8'b11011000;
    fb = 8'b11100110;
    for (int cyc = 0; cyc <= 56; cyc++) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 22 && (cyc - 1) % 3 == 0) chk("b2b_f1_y", c_if.Y, 32'(fa[(cyc-1)/3]));
      if (cyc == 2) chk("b2b_f1_hold", c_if.Y, 0);
      if (cyc == 25) chk("b2b_bitti1", c_if.bitti, 1);
      if (cyc == 26) begin
        chk("b2b_bekle_m", c_if.mesgul, 1);
        chk("b2b_bekle_b", c_if.bitti, 0);
      end
      if (cyc >= 28 && cyc <= 49 && (cyc - 28) % 3 == 0) chk("b2b_f2_y", c_if.Y, 32'(fb[(cyc-28)/3]));
      if (cyc == 52) chk("b2b_bitti2", c_if.bitti, 1);
      if (cyc == 55) begin
        chk("b2b_f3_start", c_if.Y, 0);
        chk("b2b_f3_m", c_if.mesgul, 1);
      end
      set_in(2, cyc % 3 == 0, 1'b1, cyc % 2 == 1 ? 8'h13 : 8'h0C);
    end
    set_in(2, 1'b0, 1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
